control_unit_sequencer: RTL and testbench
=========================================

# control_unit_sequencer

Multi-cycle successor to the single-cycle decode control unit, in the decode stage between fetch and the ID/EX pipeline register. It decodes a parametrised-width opcode into the same control-bundle family and adds sequenced behaviour: two-word immediate instructions, a three-cycle hardware interrupt entry (push PC, push flags, load vector) and a two-cycle RTI return. A registered FSM plus a latched interrupt-pending flag drive combinational control outputs.

## Interface
- OPCODE_W, 5: opcode width; values ≥ 9 are unmapped.
- ALU_FUNC_W, 3: ALU function field width.
- i_clk  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_op_code  in  OPCODE_W  opcode of the instruction word in decode
- i_valid  in  1  decode word valid
- i_stall  in  1  hazard stall; hold state, emit bubble
- i_interrupt  in  1  external interrupt request, one-cycle pulse or level
- o_alu_function  out  ALU_FUNC_W  0 pass, 1 NOT, 2 ADD
- o_wb_selector  out  2  0 ALU, 1 memory, 2 immediate
- o_write_back, o_mem_read, o_mem_write, o_imm, o_read1, o_read2  out  1 each  control bits
- o_stack_operation  out  1  SP-addressed memory access
- o_stack_function  out  1  0 push (pre-dec), 1 pop (post-inc)
- o_push_pc, o_pop_pc, o_push_flags, o_pop_flags  out  1 each  stack data select
- o_load_vector  out  1  PC ← vector of o_vector_sel
- o_vector_sel  out  1  0 external interrupt, 1 illegal-opcode trap
- o_freeze_fetch  out  1  hold PC and IF/ID this cycle
- o_int_ack  out  1  one-cycle acknowledge on vector load
- o_busy  out  1  FSM not in RUN

## Operation
- Opcodes: 0 NOP, 1 LDM (2-word), 2 STD, 3 ADD, 4 NOT, 5 IADD (2-word), 6 PUSH, 7 POP, 8 RTI.
- States: RUN, IMM, INT_PC, INT_FLAGS, INT_VEC, RTI_PC.
- All outputs default 0. Bubble = all outputs 0 except o_freeze_fetch where stated.
- RUN, i_valid=0 or i_stall=1: bubble, no transition.
- RUN decode:
  - NOP: read1 = read2 = 0.
  - ADD: alu = 2, write_back, read1, read2.
  - NOT: alu = 1, write_back, read1.
  - STD: mem_write, read1, read2.
  - PUSH: stack_operation, mem_write, stack_function = 0, read1.
  - POP: stack_operation, mem_read, stack_function = 1, write_back, wb_selector = 1.
  - LDM/IADD: read1 only, → IMM.
  - RTI: stack_operation, mem_read, stack_function = 1, pop_flags, freeze_fetch, → RTI_PC.
- IMM: fetched word is the immediate.
  - LDM: imm, write_back, wb_selector = 2.
  - IADD: imm, alu = 2, write_back, read1.
  - Then → RUN.
- RTI_PC: stack pop, mem_read, pop_pc, → RUN.
- Interrupt pending flag: pending ← i_interrupt | (pending & ~take).
- Take interrupt in RUN only when pending=1, i_valid=1 and i_stall=0. Priority over any opcode, including RTI.
- On take, the current opcode is not executed; freeze_fetch holds it for replay.
- INT_PC: stack push, mem_write, push_pc, freeze_fetch → INT_FLAGS.
- INT_FLAGS: push with push_flags, freeze_fetch → INT_VEC.
- INT_VEC: load_vector, int_ack → RUN.
- Never take an interrupt in IMM, RTI_PC or INT_* states; it stays pending.
- i_stall in any non-RUN state: bubble (freeze_fetch kept if the state asserts it), state held.

## Timing
- Reset (async, immediate): state = RUN, pending = 0. With i_valid=0 every output is 0; o_busy = 0.
- Outputs are combinational from state/opcode, same cycle. State and pending update on the rising edge.
- Latency: single-word instruction 1 cycle; LDM/IADD 2; RTI 2; interrupt entry 3 cycles from take, vector PC fetched on the 4th.
- A pulse arriving during IMM is taken on the first eligible RUN cycle after.
- i_interrupt high in the take cycle re-pends: a level source re-enters after INT_VEC.
- Reset mid-sequence aborts to RUN; the partial stack push is not undone.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An unmapped opcode (≥ 9) in RUN with i_valid=1 and no stall enters INT_PC with o_vector_sel = 1. The offending word is not replayed (no freeze in that cycle).
  - A pending external interrupt wins over the trap in the same cycle.
- ILLEGAL_TRAP_EN undefined: unmapped opcodes decode as NOP; o_vector_sel tied to 0.

## Test plan
- Reset mid-INT_FLAGS → all outputs 0, o_busy = 0 immediately; next valid ADD (3) gives alu = 2, write_back = 1.
- LDM (1) then next word → cycle 1 read1 only, cycle 2 imm = 1, wb_selector = 2, write_back = 1; o_busy = 1 only in cycle 2.
- One-cycle i_interrupt pulse with ADD in decode → ADD suppressed; INT_PC push_pc, INT_FLAGS push_flags, INT_VEC load_vector + int_ack with vector_sel = 0; ADD then executes.
- Interrupt pulse during IMM of IADD → IADD completes (alu = 2, imm = 1), interrupt taken on the next RUN cycle.
- RTI (8) with i_stall asserted 2 cycles in RTI_PC → pop_flags cycle, 2 bubble cycles, then pop_pc; exactly one pop of each.
- Opcode 20: with ILLEGAL_TRAP_EN → 3-cycle entry, vector_sel = 1; without it → NOP outputs, o_busy stays 0.

Source files
------------

// File: rtl/control_unit_sequencer.sv
// Multi-cycle decode control unit: opcode decode plus sequenced two-word immediates,
// interrupt entry and RTI return. Optional illegal-opcode trap under ILLEGAL_TRAP_EN.
module control_unit_sequencer #(
   parameter int OPCODE_W   = 5,
   parameter int ALU_FUNC_W = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [OPCODE_W-1:0]   i_op_code,
   input  logic                  i_valid,
   input  logic                  i_stall,
   input  logic                  i_interrupt,
   output logic [ALU_FUNC_W-1:0] o_alu_function,
   output logic [1:0]            o_wb_selector,
   output logic                  o_write_back,
   output logic                  o_mem_read,
   output logic                  o_mem_write,
   output logic                  o_imm,
   output logic                  o_read1,
   output logic                  o_read2,
   output logic                  o_stack_operation,
   output logic                  o_stack_function,
   output logic                  o_push_pc,
   output logic                  o_pop_pc,
   output logic                  o_push_flags,
   output logic                  o_pop_flags,
   output logic                  o_load_vector,
   output logic                  o_vector_sel,
   output logic                  o_freeze_fetch,
   output logic                  o_int_ack,
   output logic                  o_busy
);

   typedef enum logic [2:0] {
      RUN, IMM, INT_PC, INT_FLAGS, INT_VEC, RTI_PC
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_LDM  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_STD  = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_IADD = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_PUSH = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_POP  = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_RTI  = OPCODE_W'(8);

   localparam logic [ALU_FUNC_W-1:0] ALU_NOT = ALU_FUNC_W'(1);
   localparam logic [ALU_FUNC_W-1:0] ALU_ADD = ALU_FUNC_W'(2);

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   logic   iadd_q, iadd_d;
   logic   take;

`ifdef ILLEGAL_TRAP_EN
   logic   vec_sel_q, vec_sel_d;
   logic   illegal;
   assign illegal = (i_op_code > OP_RTI);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= RUN;
         pending_q <= 1'b0;
         iadd_q    <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
         vec_sel_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         iadd_q    <= iadd_d;
`ifdef ILLEGAL_TRAP_EN
         vec_sel_q <= vec_sel_d;
`endif
      end
   end

   assign pending_d = i_interrupt | (pending_q & ~take);
   assign o_busy    = (state_q != RUN);

   // NOTE: every output and next-state signal gets a default first, so no latch can be inferred.
   always_comb begin
      state_d           = state_q;
      iadd_d            = iadd_q;
      take              = 1'b0;
      o_alu_function    = '0;
      o_wb_selector     = 2'd0;
      o_write_back      = 1'b0;
      o_mem_read        = 1'b0;
      o_mem_write       = 1'b0;
      o_imm             = 1'b0;
      o_read1           = 1'b0;
      o_read2           = 1'b0;
      o_stack_operation = 1'b0;
      o_stack_function  = 1'b0;
      o_push_pc         = 1'b0;
      o_pop_pc          = 1'b0;
      o_push_flags      = 1'b0;
      o_pop_flags       = 1'b0;
      o_load_vector     = 1'b0;
      o_vector_sel      = 1'b0;
      o_freeze_fetch    = 1'b0;
      o_int_ack         = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      vec_sel_d         = vec_sel_q;
`endif

      case (state_q)
         RUN: begin
            if (i_valid && !i_stall) begin
               if (pending_q) begin
                  // Interrupt beats any opcode; the held word is replayed after the vector load.
                  take           = 1'b1;
                  o_freeze_fetch = 1'b1;
                  state_d        = INT_PC;
`ifdef ILLEGAL_TRAP_EN
                  vec_sel_d      = 1'b0;
               end else if (illegal) begin
                  state_d        = INT_PC;
                  vec_sel_d      = 1'b1;
`endif
               end else begin
                  case (i_op_code)
                     OP_NOP: ;
                     OP_LDM, OP_IADD: begin
                        o_read1 = 1'b1;
                        iadd_d  = (i_op_code == OP_IADD);
                        state_d = IMM;
                     end
                     OP_STD: begin
                        o_mem_write = 1'b1;
                        o_read1     = 1'b1;
                        o_read2     = 1'b1;
                     end
                     OP_ADD: begin
                        o_alu_function = ALU_ADD;
                        o_write_back   = 1'b1;
                        o_read1        = 1'b1;
                        o_read2        = 1'b1;
                     end
                     OP_NOT: begin
                        o_alu_function = ALU_NOT;
                        o_write_back   = 1'b1;
                        o_read1        = 1'b1;
                     end
                     OP_PUSH: begin
                        o_stack_operation = 1'b1;
                        o_mem_write       = 1'b1;
                        o_read1           = 1'b1;
                     end
                     OP_POP: begin
                        o_stack_operation = 1'b1;
                        o_mem_read        = 1'b1;
                        o_stack_function  = 1'b1;
                        o_write_back      = 1'b1;
                        o_wb_selector     = 2'd1;
                     end
                     OP_RTI: begin
                        o_stack_operation = 1'b1;
                        o_mem_read        = 1'b1;
                        o_stack_function  = 1'b1;
                        o_pop_flags       = 1'b1;
                        o_freeze_fetch    = 1'b1;
                        state_d           = RTI_PC;
                     end
                     default: ;
                  endcase
               end
            end
         end

         IMM: begin
            // The immediate must actually be present in decode before it is consumed.
            if (i_valid && !i_stall) begin
               o_imm        = 1'b1;
               o_write_back = 1'b1;
               if (iadd_q) begin
                  o_alu_function = ALU_ADD;
                  o_read1        = 1'b1;
               end else begin
                  o_wb_selector  = 2'd2;
               end
               state_d = RUN;
            end
         end

         INT_PC: begin
            o_freeze_fetch = 1'b1;
            if (!i_stall) begin
               o_stack_operation = 1'b1;
               o_mem_write       = 1'b1;
               o_push_pc         = 1'b1;
               state_d           = INT_FLAGS;
            end
         end

         INT_FLAGS: begin
            o_freeze_fetch = 1'b1;
            if (!i_stall) begin
               o_stack_operation = 1'b1;
               o_mem_write       = 1'b1;
               o_push_flags      = 1'b1;
               state_d           = INT_VEC;
            end
         end

         INT_VEC: begin
            if (!i_stall) begin
               o_load_vector = 1'b1;
`ifdef ILLEGAL_TRAP_EN
               // A trap is internal, so the external source is not acknowledged.
               o_vector_sel  = vec_sel_q;
               o_int_ack     = ~vec_sel_q;
`else
               o_int_ack     = 1'b1;
`endif
               state_d       = RUN;
            end
         end

         RTI_PC: begin
            if (!i_stall) begin
               o_stack_operation = 1'b1;
               o_mem_read        = 1'b1;
               o_stack_function  = 1'b1;
               o_pop_pc          = 1'b1;
               state_d           = RUN;
            end
         end

         default: state_d = RUN;
      endcase
   end

endmodule

// File: tb/tb_control_unit_sequencer.sv
// Self-checking bench for control_unit_sequencer: directed scenarios then random traffic,
// compared each cycle against a micro-step queue model. Honours ILLEGAL_TRAP_EN.
module tb_control_unit_sequencer;

   typedef struct packed {
      logic [2:0] alu;
      logic [1:0] wb_sel;
      logic       write_back, mem_read, mem_write, imm, read1, read2;
      logic       stack_op, stack_fn, push_pc, pop_pc, push_flags, pop_flags;
      logic       load_vector, vector_sel, freeze, int_ack, busy;
   } ctrl_t;

   typedef struct {
      ctrl_t c;
      bit    wait_valid;
   } step_t;

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] op;
   logic       valid, stall, intr;
   logic [2:0] alu_function;
   logic [1:0] wb_selector;
   logic       write_back, mem_read, mem_write, imm, read1, read2;
   logic       stack_operation, stack_function, push_pc, pop_pc, push_flags, pop_flags;
   logic       load_vector, vector_sel, freeze_fetch, int_ack, busy;

   control_unit_sequencer dut (
      .i_clk(clk), .i_reset(rst), .i_op_code(op), .i_valid(valid), .i_stall(stall),
      .i_interrupt(intr), .o_alu_function(alu_function), .o_wb_selector(wb_selector),
      .o_write_back(write_back), .o_mem_read(mem_read), .o_mem_write(mem_write),
      .o_imm(imm), .o_read1(read1), .o_read2(read2), .o_stack_operation(stack_operation),
      .o_stack_function(stack_function), .o_push_pc(push_pc), .o_pop_pc(pop_pc),
      .o_push_flags(push_flags), .o_pop_flags(pop_flags), .o_load_vector(load_vector),
      .o_vector_sel(vector_sel), .o_freeze_fetch(freeze_fetch), .o_int_ack(int_ack),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   ctrl_t act;
   assign act = {alu_function, wb_selector, write_back, mem_read, mem_write, imm, read1, read2,
                 stack_operation, stack_function, push_pc, pop_pc, push_flags, pop_flags,
                 load_vector, vector_sel, freeze_fetch, int_ack, busy};

   // Model: the remaining micro-steps of the instruction in flight, plus the pending flag.
   step_t prog[$];
   bit    pending;
   int    compared   = 0;
   int    mismatched = 0;
   int    pop_flags_n, pop_pc_n;

   task automatic push_int_seq(input bit vs);
      step_t s;
      s.wait_valid = 1'b0;
      s.c = '0; s.c.stack_op = 1; s.c.mem_write = 1; s.c.push_pc = 1; s.c.freeze = 1;
      prog.push_back(s);
      s.c = '0; s.c.stack_op = 1; s.c.mem_write = 1; s.c.push_flags = 1; s.c.freeze = 1;
      prog.push_back(s);
      s.c = '0; s.c.load_vector = 1; s.c.vector_sel = vs; s.c.int_ack = !vs;
      prog.push_back(s);
   endtask

   task automatic model(input bit commit, output ctrl_t e);
      bit    take;
      step_t s;
      take = 1'b0;
      e    = '0;
      s.c  = '0;
      s.wait_valid = 1'b1;
      if (prog.size() == 0) begin
         if (valid && !stall) begin
            if (pending) begin
               e.freeze = 1; take = 1'b1;
               if (commit) push_int_seq(1'b0);
            end else if (TRAP_EN && op >= 5'd9) begin
               if (commit) push_int_seq(1'b1);
            end else begin
               case (int'(op))
                  1: begin
                     e.read1 = 1;
                     s.c.imm = 1; s.c.write_back = 1; s.c.wb_sel = 2;
                     if (commit) prog.push_back(s);
                  end
                  2: begin e.mem_write = 1; e.read1 = 1; e.read2 = 1; end
                  3: begin e.alu = 2; e.write_back = 1; e.read1 = 1; e.read2 = 1; end
                  4: begin e.alu = 1; e.write_back = 1; e.read1 = 1; end
                  5: begin
                     e.read1 = 1;
                     s.c.imm = 1; s.c.alu = 2; s.c.write_back = 1; s.c.read1 = 1;
                     if (commit) prog.push_back(s);
                  end
                  6: begin e.stack_op = 1; e.mem_write = 1; e.read1 = 1; end
                  7: begin
                     e.stack_op = 1; e.mem_read = 1; e.stack_fn = 1;
                     e.write_back = 1; e.wb_sel = 1;
                  end
                  8: begin
                     e.stack_op = 1; e.mem_read = 1; e.stack_fn = 1;
                     e.pop_flags = 1; e.freeze = 1;
                     s.wait_valid = 1'b0;
                     s.c.stack_op = 1; s.c.mem_read = 1; s.c.stack_fn = 1; s.c.pop_pc = 1;
                     if (commit) prog.push_back(s);
                  end
                  default: ;
               endcase
            end
         end
      end else begin
         if (!stall && (!prog[0].wait_valid || valid)) begin
            e = prog[0].c;
            if (commit) void'(prog.pop_front());
         end else begin
            e.freeze = prog[0].c.freeze;
         end
         e.busy = 1;
      end
      if (commit) pending = intr | (pending & ~take);
   endtask

   task automatic check(input string tag, input ctrl_t a, input ctrl_t e);
      compared++;
      assert (a === e) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, a, e);
      end
   endtask

   task automatic cycle(input bit v, input bit s, input int o, input bit i, input string tag);
      ctrl_t e;
      valid = v; stall = s; op = 5'(o); intr = i;
      @(negedge clk);
      model(1'b1, e);
      check(tag, act, e);
      pop_flags_n += int'(act.pop_flags);
      pop_pc_n    += int'(act.pop_pc);
      @(posedge clk);
      #1;
   endtask

   task automatic int_entry(input bit i, input string tag);
      cycle(1, 0, 3, i, {tag, "_pc"});
      cycle(1, 0, 3, i, {tag, "_flags"});
      cycle(1, 0, 3, i, {tag, "_vec"});
   endtask

   initial begin
      ctrl_t e;
      rst = 1'b1; valid = 0; stall = 0; op = '0; intr = 0;
      pending = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model(1'b0, e);
      check("reset_state", act, e);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(0, 0, 0, 0, "idle");

      cycle(1, 0, 1, 0, "ldm_c1");
      cycle(1, 0, 0, 0, "ldm_c2");

      cycle(0, 0, 0, 1, "pulse");
      cycle(1, 0, 3, 0, "take_add");
      int_entry(0, "int");
      cycle(1, 0, 3, 0, "add_replay");

      cycle(1, 0, 5, 0, "iadd_c1");
      cycle(1, 0, 0, 1, "iadd_imm_pulse");
      cycle(1, 0, 3, 0, "iadd_take");
      int_entry(0, "iadd_int");
      cycle(1, 0, 3, 0, "iadd_after");

      pop_flags_n = 0; pop_pc_n = 0;
      cycle(1, 0, 8, 0, "rti_flags");
      cycle(1, 1, 0, 0, "rti_stall1");
      cycle(1, 1, 0, 0, "rti_stall2");
      cycle(1, 0, 0, 0, "rti_pc");
      cycle(1, 0, 0, 0, "rti_done");
      compared++;
      assert (pop_flags_n == 1) else begin
         mismatched++;
         $error("FAIL rti_pop_flags_count: observed %0d expected 1", pop_flags_n);
      end
      compared++;
      assert (pop_pc_n == 1) else begin
         mismatched++;
         $error("FAIL rti_pop_pc_count: observed %0d expected 1", pop_pc_n);
      end

      cycle(1, 0, 20, 0, "op20");
      cycle(0, 0, 0, 0, "op20_a");
      cycle(0, 0, 0, 0, "op20_b");
      cycle(0, 0, 0, 0, "op20_c");
      cycle(1, 0, 3, 0, "op20_after");

      cycle(0, 0, 0, 1, "tp_pend");
      cycle(1, 0, 20, 0, "tp_take");
      int_entry(0, "tp_int");

      cycle(1, 0, 3, 1, "lvl_set");
      cycle(1, 0, 3, 1, "lvl_take");
      int_entry(1, "lvl_int");
      cycle(1, 0, 3, 0, "lvl_retake");
      int_entry(0, "lvl_int2");
      cycle(1, 0, 3, 0, "lvl_done");

      cycle(1, 0, 6, 1, "rst_push");
      cycle(1, 0, 3, 0, "rst_take");
      cycle(1, 0, 3, 0, "rst_int_pc");
      valid = 0; intr = 0;
      #2 rst = 1'b1;
      #1;
      prog.delete();
      pending = 1'b0;
      model(1'b0, e);
      check("rst_mid_flags", act, e);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 0, 3, 0, "rst_add");

      for (int n = 0; n < 400; n++) begin
         cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
               int'($urandom_range(0, 31)), $urandom_range(0, 19) == 0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
